// File: rtl/noc_packetizer.sv
// Packetizer between a PE write port and a NoC input: one head flit, BEATS body flits MSB-first,
// and a parity tail flit when PKT_PARITY_EN is defined.
module noc_packetizer #(
  parameter int unsigned DataWidth    = 8,
  parameter int unsigned PayloadWidth = 32,
  parameter logic [1:0]  SRC_ID       = 2'b00
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    write,
  input  logic [1:0]              address,
  input  logic [PayloadWidth-1:0] writeData,
  output logic                    waitRequest,
  output logic [DataWidth-1:0]    flit_data,
  output logic                    flit_en,
  input  logic                    flit_ready
);

  localparam int unsigned BEATS = PayloadWidth / DataWidth;
  localparam int unsigned SEQW  = DataWidth - 4;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

`ifdef PKT_PARITY_EN
  typedef enum logic [1:0] {IDLE, HEAD, BODY, TAIL} state_t;
`else
  typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;
`endif

  state_t                  state_q, state_d;
  logic [BW-1:0]           beat_q, beat_d;
  logic [SEQW-1:0]         seq_q, seq_d;
  logic [PayloadWidth-1:0] payload_q, payload_d;
  logic [1:0]              dest_q, dest_d;
  logic [DataWidth-1:0]    flit_data_q, flit_data_d;
  logic                    flit_en_q, flit_en_d;
  logic                    wait_q, wait_d;

  // Body slice idx, counted from the most significant end of the payload.
  function automatic logic [DataWidth-1:0] get_slice(input logic [PayloadWidth-1:0] p,
                                                     input logic [BW-1:0] idx);
    logic [PayloadWidth-1:0] sh;
    sh = p >> (DataWidth * (BEATS - 1 - 32'(idx)));
    return sh[DataWidth-1:0];
  endfunction

`ifdef PKT_PARITY_EN
  function automatic logic [DataWidth-1:0] get_parity(input logic [PayloadWidth-1:0] p);
    logic [DataWidth-1:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < BEATS; i++) acc ^= p[i*DataWidth +: DataWidth];
    return acc;
  endfunction
`endif

  // Next state and next registered outputs; each output flop carries the value for the next cycle.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    seq_d       = seq_q;
    payload_d   = payload_q;
    dest_d      = dest_q;
    flit_data_d = flit_data_q;
    flit_en_d   = flit_en_q;
    wait_d      = wait_q;
    case (state_q)
      IDLE: begin
        if (write) begin
          dest_d      = address;
          payload_d   = writeData;
          state_d     = HEAD;
          flit_en_d   = 1'b1;
          wait_d      = 1'b1;
          flit_data_d = {address, SRC_ID, seq_q};
        end
      end
      HEAD: begin
        if (flit_ready) begin
          seq_d       = seq_q + SEQW'(1);
          beat_d      = '0;
          state_d     = BODY;
          flit_data_d = get_slice(payload_q, '0);
        end
      end
      BODY: begin
        if (flit_ready) begin
          if (beat_q == BW'(BEATS - 1)) begin
`ifdef PKT_PARITY_EN
            state_d     = TAIL;
            flit_data_d = get_parity(payload_q);
`else
            state_d     = IDLE;
            flit_en_d   = 1'b0;
            wait_d      = 1'b0;
            flit_data_d = '0;
`endif
          end else begin
            beat_d      = beat_q + BW'(1);
            flit_data_d = get_slice(payload_q, beat_q + BW'(1));
          end
        end
      end
`ifdef PKT_PARITY_EN
      TAIL: begin
        if (flit_ready) begin
          state_d     = IDLE;
          flit_en_d   = 1'b0;
          wait_d      = 1'b0;
          flit_data_d = '0;
        end
      end
`endif
      default: begin
        state_d     = IDLE;
        flit_en_d   = 1'b0;
        wait_d      = 1'b0;
        flit_data_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      seq_q       <= '0;
      payload_q   <= '0;
      dest_q      <= '0;
      flit_data_q <= '0;
      flit_en_q   <= 1'b0;
      wait_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      seq_q       <= seq_d;
      payload_q   <= payload_d;
      dest_q      <= dest_d;
      flit_data_q <= flit_data_d;
      flit_en_q   <= flit_en_d;
      wait_q      <= wait_d;
    end
  end

  assign waitRequest = wait_q;
  assign flit_data   = flit_data_q;
  assign flit_en     = flit_en_q;

endmodule
